// File: rtl/pixel_write_buffer.sv
// Double-banked output buffer: captures a window of pixels on i_save and drains
// it to the SRAM write controller one word per write-enable/write-complete handshake.
module pixel_write_buffer #(
   parameter int NUM_PIX = 9,
   parameter int PIX_W = 8,
   parameter int WORD_W = 32,
   parameter int PACK = 0,
   localparam int LANES = WORD_W / PIX_W,
   localparam int NWORDS = (PACK != 0) ? (NUM_PIX + LANES - 1) / LANES : NUM_PIX,
   localparam int IDX_W = $clog2(NWORDS) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_PIX*PIX_W-1:0] i_pix,
   input  logic                     i_save,
   input  logic                     i_write_complete,
   output logic [WORD_W-1:0]        o_data,
   output logic                     o_write_enable,
   output logic [IDX_W-1:0]         o_word_idx,
   output logic                     o_empty,
   output logic                     o_full,
   output logic                     o_overflow
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_WAIT  = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   logic [NUM_PIX*PIX_W-1:0] bank_q [2];
   logic [1:0]               valid_q;
   logic [1:0]               valid_released;
   logic [1:0]               valid_next;
   logic                     wr_ptr_q;
   logic                     rd_ptr_q;
   logic                     rd_ptr_next;
   logic [1:0]               state_q;
   logic [1:0]               state_next;
   logic [IDX_W-1:0]         idx_q;
   logic [IDX_W-1:0]         idx_next;
   logic                     last_word;
   logic                     release_bank;
   logic                     save_ok;
   logic [NUM_PIX*PIX_W-1:0] sel_bank;
   logic [WORD_W-1:0]        word_next;
   logic [PIX_W-1:0]         pix_val;
   int                       pix_num;

   // A bank whose last word completes this cycle is free for a same-cycle save.
   always_comb begin
      last_word = (idx_q == LAST_IDX);
      release_bank = (state_q == ST_WAIT) && i_write_complete && last_word;
      valid_released = valid_q;
      if (release_bank) begin
         valid_released[rd_ptr_q] = 1'b0;
      end
      save_ok = i_save && !valid_released[wr_ptr_q];
      valid_next = valid_released;
      if (save_ok) begin
         valid_next[wr_ptr_q] = 1'b1;
      end
   end

   always_comb begin
      state_next = state_q;
      idx_next = idx_q;
      rd_ptr_next = rd_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_q[rd_ptr_q]) begin
               state_next = ST_LOAD;
               idx_next = '0;
            end
         end
         ST_LOAD: state_next = ST_WRITE;
         ST_WRITE: state_next = ST_WAIT;
         ST_WAIT: begin
            if (i_write_complete) begin
               if (!last_word) begin
                  idx_next = idx_q + IDX_W'(1);
                  state_next = ST_LOAD;
               end else begin
                  idx_next = '0;
                  rd_ptr_next = ~rd_ptr_q;
                  state_next = valid_q[~rd_ptr_q] ? ST_LOAD : ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Word presented on entry to LOAD; lane 0 sits in the MSBs, unused lanes read zero.
   always_comb begin
      sel_bank = bank_q[rd_ptr_next];
      word_next = '0;
      pix_num = 0;
      pix_val = '0;
      for (int j = 0; j < LANES; j++) begin
         pix_num = (PACK != 0) ? int'(idx_next) * LANES + j : int'(idx_next);
         pix_val = '0;
         for (int k = 0; k < NUM_PIX; k++) begin
            if (k == pix_num) begin
               pix_val = sel_bank[k*PIX_W +: PIX_W];
            end
         end
         word_next[(LANES-1-j)*PIX_W +: PIX_W] = pix_val;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && save_ok) begin
         bank_q[wr_ptr_q] <= i_pix;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 2'b00;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         state_q <= ST_IDLE;
         idx_q <= '0;
         o_data <= '0;
         o_write_enable <= 1'b0;
         o_word_idx <= '0;
         o_empty <= 1'b1;
         o_full <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         valid_q <= valid_next;
         if (save_ok) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         rd_ptr_q <= rd_ptr_next;
         state_q <= state_next;
         idx_q <= idx_next;
         if (state_next == ST_LOAD && state_q != ST_LOAD) begin
            o_data <= word_next;
            o_word_idx <= idx_next;
         end
         o_write_enable <= (state_next == ST_WRITE);
         o_full <= &valid_next;
         o_empty <= (valid_next == 2'b00) && (state_next == ST_IDLE);
         o_overflow <= i_save && !save_ok;
      end
   end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: one replicate-mode instance and one
// pack-mode instance sharing clock, reset and pixel inputs.
module tb_pixel_write_buffer;

   logic        clk;
   logic        rst;
   logic [71:0] pix;
   logic        save0, wc0, save1, wc1;
   logic [31:0] data0, data1;
   logic        we0, we1;
   logic [4:0]  idx0;
   logic [2:0]  idx1;
   logic        empty0, full0, ovf0;
   logic        empty1, full1, ovf1;
   int          tests_run;
   int          tests_failed;

   pixel_write_buffer #(.NUM_PIX(9), .PIX_W(8), .WORD_W(32), .PACK(0)) dut0 (
      .clk(clk), .rst(rst), .i_pix(pix), .i_save(save0), .i_write_complete(wc0),
      .o_data(data0), .o_write_enable(we0), .o_word_idx(idx0),
      .o_empty(empty0), .o_full(full0), .o_overflow(ovf0)
   );

   pixel_write_buffer #(.NUM_PIX(9), .PIX_W(8), .WORD_W(32), .PACK(1)) dut1 (
      .clk(clk), .rst(rst), .i_pix(pix), .i_save(save1), .i_write_complete(wc1),
      .o_data(data1), .o_write_enable(we1), .o_word_idx(idx1),
      .o_empty(empty1), .o_full(full1), .o_overflow(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pix(input logic [7:0] base);
      for (int k = 0; k < 9; k++) pix[k*8 +: 8] = base + 8'(k);
   endtask

   function automatic logic [31:0] rep(input logic [7:0] b);
      return {b, b, b, b};
   endfunction

   task automatic do_reset();
      rst = 1'b1; save0 = 1'b0; save1 = 1'b0; wc0 = 1'b0; wc1 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (data0 !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data0: got %h expected %h", data0, 32'h0); end
      tests_run++; if (we0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we0: got %b expected 0", we0); end
      tests_run++; if (idx0 !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_idx0: got %0d expected 0", idx0); end
      tests_run++; if (empty0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty0: got %b expected 1", empty0); end
      tests_run++; if (full0 !== 1'b0 || ovf0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags0: full %b ovf %b expected 0 0", full0, ovf0); end
      tests_run++; if (data1 !== 32'h0 || we1 !== 1'b0 || idx1 !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_out1: data %h we %b idx %0d expected 0 0 0", data1, we1, idx1); end
      tests_run++; if (empty1 !== 1'b1 || full1 !== 1'b0 || ovf1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags1: empty %b full %b ovf %b expected 1 0 0", empty1, full1, ovf1); end
   endtask

   task automatic test_replicate();
      int t, w, done, resp_at, extra;
      bit pending;
      logic [31:0] exp;
      do_reset();
      set_pix(8'h10);
      save0 = 1'b1; tick(); save0 = 1'b0;
      tests_run++; if (empty0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rep_empty_after_save: got %b expected 0", empty0); end
      t = 1; w = 0; done = 0; pending = 0; resp_at = 0;
      while (done < 9 && t < 400) begin
         if (we0) begin
            exp = rep(8'h10 + 8'(w));
            tests_run++;
            if (data0 !== exp || idx0 !== 5'(w)) begin
               tests_failed++;
               $display("[TB] FAIL rep_word%0d: got data %h idx %0d expected %h idx %0d", w, data0, idx0, exp, w);
            end
            w++; pending = 1; resp_at = t + 2;
         end
         wc0 = pending && (t == resp_at);
         if (wc0) begin pending = 0; done++; end
         tick(); wc0 = 1'b0; t++;
      end
      tests_run++; if (done != 9) begin tests_failed++; $display("[TB] FAIL rep_timeout: got %0d completes expected 9", done); end
      tests_run++; if (empty0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL rep_empty_end: got %b expected 1", empty0); end
      extra = 0;
      repeat (10) begin if (we0) extra++; tick(); end
      tests_run++; if (extra != 0) begin tests_failed++; $display("[TB] FAIL rep_extra_writes: got %0d expected 0", extra); end
   endtask

   task automatic test_pack();
      int t, w, done, resp_at;
      bit pending;
      logic [31:0] exp_tab [3];
      exp_tab[0] = 32'h10111213; exp_tab[1] = 32'h14151617; exp_tab[2] = 32'h18000000;
      do_reset();
      set_pix(8'h10);
      save1 = 1'b1; tick(); save1 = 1'b0;
      t = 1; w = 0; done = 0; pending = 0; resp_at = 0;
      while (done < 3 && t < 200) begin
         if (we1) begin
            tests_run++;
            if (w > 2) begin
               tests_failed++; $display("[TB] FAIL pack_extra_write: got idx %0d expected no write", idx1);
            end else if (data1 !== exp_tab[w] || idx1 !== 3'(w)) begin
               tests_failed++;
               $display("[TB] FAIL pack_word%0d: got data %h idx %0d expected %h idx %0d", w, data1, idx1, exp_tab[w], w);
            end
            w++; pending = 1; resp_at = t + 2;
         end
         wc1 = pending && (t == resp_at);
         if (wc1) begin pending = 0; done++; end
         tick(); wc1 = 1'b0; t++;
      end
      tests_run++; if (done != 3) begin tests_failed++; $display("[TB] FAIL pack_timeout: got %0d completes expected 3", done); end
      tests_run++; if (empty1 !== 1'b1) begin tests_failed++; $display("[TB] FAIL pack_empty_end: got %b expected 1", empty1); end
   endtask

   task automatic test_ping_pong();
      int t, w, done, resp_at, c9_t, we10_t, extra;
      bit pending;
      logic [31:0] exp;
      do_reset();
      t = 0; w = 0; done = 0; pending = 0; resp_at = 0; c9_t = -100; we10_t = -1;
      while (done < 18 && t < 600) begin
         save0 = (t == 0 || t == 5 || t == 6);
         if (t == 0) set_pix(8'h10);
         if (t == 5) set_pix(8'h20);
         if (t == 6) set_pix(8'h30);
         if (t == 6) begin
            tests_run++; if (full0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL pp_full: got %b expected 1", full0); end
         end
         if (t == 7) begin
            tests_run++; if (ovf0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL pp_overflow: got %b expected 1", ovf0); end
         end
         if (we0) begin
            exp = (w < 9) ? rep(8'h10 + 8'(w)) : rep(8'h20 + 8'(w - 9));
            tests_run++;
            if (w >= 18 || data0 !== exp) begin
               tests_failed++; $display("[TB] FAIL pp_word%0d: got %h expected %h", w, data0, exp);
            end
            if (w == 9) we10_t = t;
            w++; pending = 1; resp_at = t + 2;
         end
         wc0 = pending && (t >= resp_at) && (t >= 8);
         if (wc0) begin pending = 0; done++; if (done == 9) c9_t = t; end
         tick(); wc0 = 1'b0; save0 = 1'b0; t++;
      end
      tests_run++; if (done != 18) begin tests_failed++; $display("[TB] FAIL pp_timeout: got %0d completes expected 18", done); end
      tests_run++; if (empty0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL pp_empty_end: got %b expected 1", empty0); end
      tests_run++; if (we10_t != c9_t + 2) begin tests_failed++; $display("[TB] FAIL pp_gap: got B first write at %0d expected %0d", we10_t, c9_t + 2); end
      extra = 0;
      repeat (20) begin if (we0) extra++; tick(); end
      tests_run++; if (extra != 0) begin tests_failed++; $display("[TB] FAIL pp_third_written: got %0d writes expected 0", extra); end
   endtask

   task automatic test_holdoff();
      int t, done, resp_at;
      bit pending, bad;
      do_reset();
      set_pix(8'h40);
      save0 = 1'b1; tick(); save0 = 1'b0;
      t = 0;
      while (!we0 && t < 10) begin tick(); t++; end
      tests_run++; if (we0 !== 1'b1 || data0 !== 32'h40404040) begin tests_failed++; $display("[TB] FAIL hold_first_write: we %b data %h expected 1 40404040", we0, data0); end
      wc0 = 1'b1; tick(); wc0 = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (data0 !== 32'h40404040 || we0 !== 1'b0 || idx0 !== 5'd0) bad = 1;
         tick();
      end
      tests_run++; if (bad) begin tests_failed++; $display("[TB] FAIL hold_stable: got data %h we %b idx %0d expected 40404040 0 0", data0, we0, idx0); end
      wc0 = 1'b1; tick(); wc0 = 1'b0;
      tests_run++; if (data0 !== 32'h41414141 || idx0 !== 5'd1 || we0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_next_data: data %h idx %0d we %b expected 41414141 1 0", data0, idx0, we0); end
      tick();
      tests_run++; if (we0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_next_we: got %b expected 1", we0); end
      t = 0; done = 0; pending = 0; resp_at = 0;
      while (done < 8 && t < 200) begin
         if (we0) begin pending = 1; resp_at = t + 1; end
         wc0 = pending && (t == resp_at);
         if (wc0) begin pending = 0; done++; end
         tick(); wc0 = 1'b0; t++;
      end
      tests_run++; if (done != 8 || empty0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_drain: got %0d completes empty %b expected 8 1", done, empty0); end
   endtask

   task automatic test_reset_mid();
      int t, resp_at, extra;
      bit pending;
      do_reset();
      set_pix(8'h10);
      save0 = 1'b1; tick(); save0 = 1'b0;
      t = 0; pending = 0; resp_at = 0;
      while (t < 200) begin
         if (we0 && idx0 == 5'd4) break;
         if (we0) begin pending = 1; resp_at = t + 2; end
         wc0 = pending && (t == resp_at);
         if (wc0) pending = 0;
         tick(); wc0 = 1'b0; t++;
      end
      tests_run++; if (!(we0 === 1'b1 && idx0 === 5'd4)) begin tests_failed++; $display("[TB] FAIL rmid_word4: got we %b idx %0d expected 1 4", we0, idx0); end
      rst = 1'b1; tick(); rst = 1'b0;
      tests_run++; if (data0 !== 32'h0 || idx0 !== 5'd0 || we0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_outputs: data %h idx %0d we %b expected 0 0 0", data0, idx0, we0); end
      tests_run++; if (empty0 !== 1'b1 || full0 !== 1'b0 || ovf0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL rmid_flags: empty %b full %b ovf %b expected 1 0 0", empty0, full0, ovf0); end
      extra = 0;
      wc0 = 1'b1;
      repeat (20) begin if (we0) extra++; tick(); end
      wc0 = 1'b0;
      tests_run++; if (extra != 0) begin tests_failed++; $display("[TB] FAIL rmid_no_write: got %0d writes expected 0", extra); end
      set_pix(8'h60);
      save0 = 1'b1; tick(); save0 = 1'b0;
      tick(); tick();
      tests_run++; if (we0 !== 1'b1 || data0 !== 32'h60606060 || idx0 !== 5'd0) begin tests_failed++; $display("[TB] FAIL rmid_restart: we %b data %h idx %0d expected 1 60606060 0", we0, data0, idx0); end
   endtask

   task automatic test_simultaneous();
      int t, w, done, resp_at, save_t;
      bit pending;
      logic [31:0] exp;
      do_reset();
      set_pix(8'h10); save0 = 1'b1; tick();
      set_pix(8'h20); tick(); save0 = 1'b0;
      tests_run++; if (full0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sim_full: got %b expected 1", full0); end
      t = 2; w = 0; done = 0; pending = 0; resp_at = 0; save_t = -100;
      while (done < 27 && t < 800) begin
         if (t == save_t + 1) begin
            tests_run++; if (ovf0 !== 1'b0 || full0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sim_accept: ovf %b full %b expected 0 1", ovf0, full0); end
         end
         if (we0) begin
            if (w < 9) exp = rep(8'h10 + 8'(w));
            else if (w < 18) exp = rep(8'h20 + 8'(w - 9));
            else exp = rep(8'h50 + 8'(w - 18));
            tests_run++;
            if (w >= 27 || data0 !== exp) begin
               tests_failed++; $display("[TB] FAIL sim_word%0d: got %h expected %h", w, data0, exp);
            end
            w++; pending = 1; resp_at = t + 1;
         end
         wc0 = pending && (t == resp_at);
         if (wc0) begin
            pending = 0; done++;
            if (done == 9) begin save0 = 1'b1; set_pix(8'h50); save_t = t; end
         end
         tick(); wc0 = 1'b0; save0 = 1'b0; t++;
      end
      tests_run++; if (done != 27 || empty0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL sim_drain: got %0d completes empty %b expected 27 1", done, empty0); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1; pix = '0; save0 = 1'b0; save1 = 1'b0; wc0 = 1'b0; wc1 = 1'b0;
      test_reset();
      test_replicate();
      test_pack();
      test_ping_pong();
      test_holdoff();
      test_reset_mid();
      test_simultaneous();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
